// File: rtl/quiz_game_if.sv
// Quiz game bus: start/buttons/answer key in, question index, scores and status out.
interface quiz_game_if #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned NUM_CHOICES = 4
);
  logic                               start;
  logic [NUM_PLAYERS*NUM_CHOICES-1:0] btn_n;
  logic [3:0]                         q_ans;
  logic [3:0]                         q_idx;
  logic [NUM_PLAYERS*4-1:0]           score;
  logic [NUM_PLAYERS-1:0]             lockout;
  logic                               round_active;
  logic [1:0]                         winner;
  logic                               game_over;
  logic                               beep;

  modport master (
    output start, btn_n, q_ans,
    input  q_idx, score, lockout, round_active, winner, game_over, beep
  );

  modport slave (
    input  start, btn_n, q_ans,
    output q_idx, score, lockout, round_active, winner, game_over, beep
  );
endinterface

// File: rtl/quiz_game_core.sv
// Multi-player quiz buzzer core: first valid press is judged, scores to WIN_SCORE.
// Optional per-question answer timeout enabled by defining QUIZ_TIMEOUT_EN.
module quiz_game_core #(
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned NUM_CHOICES    = 4,
  parameter int unsigned NUM_QUESTIONS  = 10,
  parameter int unsigned WIN_SCORE      = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  quiz_game_if.slave   bus
);

  localparam int unsigned NUM_BTN = NUM_PLAYERS * NUM_CHOICES;
  localparam int unsigned PW      = 2;
  localparam int unsigned CW      = 3;
  localparam int unsigned SW      = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ASK   = 3'd1;
  localparam logic [2:0] S_JUDGE = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic [2:0]                       r_state;
  logic [2:0]                       w_state_nxt;
  logic [NUM_BTN-1:0]               r_btn_s1;
  logic [NUM_BTN-1:0]               r_btn_s2;
  logic [NUM_BTN-1:0]               r_btn_prev;
  logic [PW-1:0]                    r_player;
  logic [CW-1:0]                    r_choice;
  logic [NUM_PLAYERS-1:0][SW-1:0]   r_score;
  logic [NUM_PLAYERS-1:0]           r_lockout;
  logic [3:0]                       r_q_idx;
  logic [1:0]                       r_winner;
  logic                             r_round_active;
  logic                             r_game_over;
  logic                             r_beep;

  logic [NUM_BTN-1:0]               w_fall;
  logic [NUM_BTN-1:0]               w_lock_mask;
  logic [NUM_BTN-1:0]               w_cand;
  logic                             w_hit;
  logic [PW-1:0]                    w_sel_p;
  logic [CW-1:0]                    w_sel_c;
  logic [NUM_PLAYERS-1:0]           w_player_oh;
  logic                             w_correct;
  logic                             w_all_locked;
  logic                             w_any_win;
  logic [1:0]                       w_win_idx;
  logic                             w_timeout;

  // Press = falling edge on the synchronised button, masked by lockout
  assign w_fall = r_btn_prev & ~r_btn_s2;
  assign w_cand = w_fall & ~w_lock_mask;

  always_comb begin
    w_lock_mask = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int c = 0; c < NUM_CHOICES; c++) begin
        w_lock_mask[p*NUM_CHOICES + c] = r_lockout[p];
      end
    end
  end

  // Flat bit order gives lowest player first, then lowest choice
  always_comb begin
    w_hit   = 1'b0;
    w_sel_p = '0;
    w_sel_c = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int c = 0; c < NUM_CHOICES; c++) begin
        if (!w_hit && w_cand[p*NUM_CHOICES + c]) begin
          w_hit   = 1'b1;
          w_sel_p = PW'(p);
          w_sel_c = CW'(c);
        end
      end
    end
  end

  always_comb begin
    w_player_oh = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_player_oh[p] = (r_player == PW'(p));
    end
  end

  assign w_correct    = ((SW'(r_choice) + 4'd1) == bus.q_ans);
  assign w_all_locked = &(r_lockout | w_player_oh);

  always_comb begin
    w_any_win = 1'b0;
    w_win_idx = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (r_score[p] == SW'(WIN_SCORE)) begin
        w_any_win = 1'b1;
        w_win_idx = 2'(p);
      end
    end
  end

`ifdef QUIZ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;

  // Holds across JUDGE so a wrong answer does not restart the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_ASK) begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end else if (r_state != S_JUDGE) begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_timeout = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_ASK;
      S_ASK: begin
        if (w_hit)          w_state_nxt = S_JUDGE;
        else if (w_timeout) w_state_nxt = S_NEXT;
      end
      S_JUDGE: begin
        if (w_correct || w_all_locked) w_state_nxt = S_NEXT;
        else                           w_state_nxt = S_ASK;
      end
      S_NEXT:  w_state_nxt = w_any_win ? S_OVER : S_ASK;
      S_OVER:  if (bus.start) w_state_nxt = S_ASK;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_s1       <= '1;
      r_btn_s2       <= '1;
      r_btn_prev     <= '1;
      r_player       <= '0;
      r_choice       <= '0;
      r_score        <= '0;
      r_lockout      <= '0;
      r_q_idx        <= '0;
      r_winner       <= '0;
      r_round_active <= 1'b0;
      r_game_over    <= 1'b0;
      r_beep         <= 1'b0;
    end else begin
      r_btn_s1       <= bus.btn_n;
      r_btn_s2       <= r_btn_s1;
      r_btn_prev     <= r_btn_s2;
      r_round_active <= (w_state_nxt == S_ASK);
      r_game_over    <= (w_state_nxt == S_OVER);
      r_beep         <= ((r_state == S_JUDGE) && w_correct) || (w_state_nxt == S_OVER);
      case (r_state)
        S_IDLE, S_OVER: begin
          if (bus.start) begin
            r_score   <= '0;
            r_lockout <= '0;
            r_q_idx   <= '0;
            r_winner  <= '0;
          end
        end
        S_ASK: begin
          if (w_hit) begin
            r_player <= w_sel_p;
            r_choice <= w_sel_c;
          end
        end
        S_JUDGE: begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (w_player_oh[p]) begin
              if (!w_correct)                       r_lockout[p] <= 1'b1;
              else if (r_score[p] < SW'(WIN_SCORE)) r_score[p]   <= r_score[p] + 4'd1;
            end
          end
        end
        S_NEXT: begin
          r_lockout <= '0;
          r_q_idx   <= (r_q_idx == 4'(NUM_QUESTIONS - 1)) ? 4'd0 : r_q_idx + 4'd1;
          if (w_any_win) r_winner <= w_win_idx;
        end
        default: ;
      endcase
    end
  end

  assign bus.q_idx        = r_q_idx;
  assign bus.score        = r_score;
  assign bus.lockout      = r_lockout;
  assign bus.round_active = r_round_active;
  assign bus.winner       = r_winner;
  assign bus.game_over    = r_game_over;
  assign bus.beep         = r_beep;

endmodule

// File: tb/tb_quiz_game_core.sv
// Directed self-checking bench for quiz_game_core (default 2 players x 4 choices).
module tb_quiz_game_core;

  localparam int unsigned NP = 2;
  localparam int unsigned NC = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  quiz_game_if #(.NUM_PLAYERS(NP), .NUM_CHOICES(NC)) bus ();

  quiz_game_core #(
    .NUM_PLAYERS(NP), .NUM_CHOICES(NC), .NUM_QUESTIONS(10),
    .WIN_SCORE(5), .TIMEOUT_CYCLES(1000000)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef QUIZ_TIMEOUT_EN
  quiz_game_if #(.NUM_PLAYERS(NP), .NUM_CHOICES(NC)) tbus ();

  quiz_game_core #(
    .NUM_PLAYERS(NP), .NUM_CHOICES(NC), .NUM_QUESTIONS(10),
    .WIN_SCORE(5), .TIMEOUT_CYCLES(16)
  ) dut_tmo (.clk(clk), .rst_n(rst_n), .bus(tbus));
`endif

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  // Hold button through sync + capture + judge, then release
  task automatic do_press(input int p, input int c);
    bus.btn_n[p*NC + c] = 1'b0;
    step(4);
    bus.btn_n = '1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    n_vec++; if (bus.q_idx !== 4'd0) begin n_err++; $display("FAIL rst_q_idx got %h exp %h", bus.q_idx, 4'd0); end
    n_vec++; if (bus.score !== 8'h00) begin n_err++; $display("FAIL rst_score got %h exp %h", bus.score, 8'h00); end
    n_vec++; if (bus.lockout !== 2'b00) begin n_err++; $display("FAIL rst_lockout got %b exp %b", bus.lockout, 2'b00); end
    n_vec++; if (bus.winner !== 2'd0) begin n_err++; $display("FAIL rst_winner got %h exp %h", bus.winner, 2'd0); end
    n_vec++; if (bus.round_active !== 1'b0) begin n_err++; $display("FAIL rst_round_active got %b exp 0", bus.round_active); end
    n_vec++; if (bus.game_over !== 1'b0) begin n_err++; $display("FAIL rst_game_over got %b exp 0", bus.game_over); end
    n_vec++; if (bus.beep !== 1'b0) begin n_err++; $display("FAIL rst_beep got %b exp 0", bus.beep); end
    rst_n = 1'b1;
    step(1);
    bus.q_ans = 4'd1;
    do_press(0, 0);
    step(3);
    n_vec++; if (bus.score !== 8'h00) begin n_err++; $display("FAIL idle_press_score got %h exp %h", bus.score, 8'h00); end
    n_vec++; if (bus.round_active !== 1'b0) begin n_err++; $display("FAIL idle_round_active got %b exp 0", bus.round_active); end
  endtask

  task automatic test_start();
    pulse_start();
    n_vec++; if (bus.round_active !== 1'b1) begin n_err++; $display("FAIL start_round_active got %b exp 1", bus.round_active); end
    n_vec++; if (bus.q_idx !== 4'd0) begin n_err++; $display("FAIL start_q_idx got %h exp %h", bus.q_idx, 4'd0); end
  endtask

  task automatic test_correct();
    bus.q_ans = 4'd3;
    do_press(0, 2);
    n_vec++; if (bus.score !== 8'h01) begin n_err++; $display("FAIL correct_score got %h exp %h", bus.score, 8'h01); end
    n_vec++; if (bus.beep !== 1'b1) begin n_err++; $display("FAIL correct_beep_hi got %b exp 1", bus.beep); end
    n_vec++; if (bus.q_idx !== 4'd0) begin n_err++; $display("FAIL correct_q_idx_pre got %h exp %h", bus.q_idx, 4'd0); end
    step(1);
    n_vec++; if (bus.beep !== 1'b0) begin n_err++; $display("FAIL correct_beep_lo got %b exp 0", bus.beep); end
    n_vec++; if (bus.q_idx !== 4'd1) begin n_err++; $display("FAIL correct_q_idx got %h exp %h", bus.q_idx, 4'd1); end
    n_vec++; if (bus.round_active !== 1'b1) begin n_err++; $display("FAIL correct_round_active got %b exp 1", bus.round_active); end
    step(2);
  endtask

  task automatic test_lockout();
    bus.q_ans = 4'd2;
    do_press(0, 0);
    n_vec++; if (bus.lockout !== 2'b01) begin n_err++; $display("FAIL lock_set got %b exp %b", bus.lockout, 2'b01); end
    n_vec++; if (bus.score !== 8'h01) begin n_err++; $display("FAIL lock_wrong_score got %h exp %h", bus.score, 8'h01); end
    n_vec++; if (bus.round_active !== 1'b1) begin n_err++; $display("FAIL lock_back_to_ask got %b exp 1", bus.round_active); end
    step(3);
    do_press(0, 1);
    n_vec++; if (bus.score !== 8'h01) begin n_err++; $display("FAIL lock_ignored_score got %h exp %h", bus.score, 8'h01); end
    n_vec++; if (bus.beep !== 1'b0) begin n_err++; $display("FAIL lock_ignored_beep got %b exp 0", bus.beep); end
    step(3);
    do_press(1, 1);
    n_vec++; if (bus.score !== 8'h11) begin n_err++; $display("FAIL lock_p1_score got %h exp %h", bus.score, 8'h11); end
    step(1);
    n_vec++; if (bus.lockout !== 2'b00) begin n_err++; $display("FAIL lock_cleared got %b exp %b", bus.lockout, 2'b00); end
    n_vec++; if (bus.q_idx !== 4'd2) begin n_err++; $display("FAIL lock_q_idx got %h exp %h", bus.q_idx, 4'd2); end
    step(2);
  endtask

  task automatic test_simultaneous();
    bus.q_ans = 4'd4;
    bus.btn_n[3] = 1'b0;
    bus.btn_n[7] = 1'b0;
    step(4);
    bus.btn_n = '1;
    n_vec++; if (bus.score !== 8'h12) begin n_err++; $display("FAIL simul_score got %h exp %h", bus.score, 8'h12); end
    n_vec++; if (bus.beep !== 1'b1) begin n_err++; $display("FAIL simul_beep got %b exp 1", bus.beep); end
    step(1);
    n_vec++; if (bus.q_idx !== 4'd3) begin n_err++; $display("FAIL simul_q_idx got %h exp %h", bus.q_idx, 4'd3); end
    step(2);
  endtask

  task automatic test_win_p0();
    bus.q_ans = 4'd1;
    repeat (3) begin
      do_press(0, 0);
      step(3);
    end
    n_vec++; if (bus.score !== 8'h15) begin n_err++; $display("FAIL win_score got %h exp %h", bus.score, 8'h15); end
    n_vec++; if (bus.game_over !== 1'b1) begin n_err++; $display("FAIL win_game_over got %b exp 1", bus.game_over); end
    n_vec++; if (bus.winner !== 2'd0) begin n_err++; $display("FAIL win_winner got %h exp %h", bus.winner, 2'd0); end
    n_vec++; if (bus.beep !== 1'b1) begin n_err++; $display("FAIL win_beep_held got %b exp 1", bus.beep); end
    n_vec++; if (bus.q_idx !== 4'd6) begin n_err++; $display("FAIL win_q_idx got %h exp %h", bus.q_idx, 4'd6); end
    n_vec++; if (bus.round_active !== 1'b0) begin n_err++; $display("FAIL win_round_active got %b exp 0", bus.round_active); end
    do_press(1, 0);
    step(3);
    n_vec++; if (bus.score !== 8'h15) begin n_err++; $display("FAIL over_press_score got %h exp %h", bus.score, 8'h15); end
    n_vec++; if (bus.game_over !== 1'b1) begin n_err++; $display("FAIL over_hold got %b exp 1", bus.game_over); end
    pulse_start();
    n_vec++; if (bus.score !== 8'h00) begin n_err++; $display("FAIL restart_score got %h exp %h", bus.score, 8'h00); end
    n_vec++; if (bus.q_idx !== 4'd0) begin n_err++; $display("FAIL restart_q_idx got %h exp %h", bus.q_idx, 4'd0); end
    n_vec++; if (bus.game_over !== 1'b0) begin n_err++; $display("FAIL restart_game_over got %b exp 0", bus.game_over); end
    n_vec++; if (bus.beep !== 1'b0) begin n_err++; $display("FAIL restart_beep got %b exp 0", bus.beep); end
    n_vec++; if (bus.round_active !== 1'b1) begin n_err++; $display("FAIL restart_round_active got %b exp 1", bus.round_active); end
  endtask

  task automatic test_all_locked();
    bus.q_ans = 4'd1;
    do_press(0, 1);
    n_vec++; if (bus.lockout !== 2'b01) begin n_err++; $display("FAIL alllock_first got %b exp %b", bus.lockout, 2'b01); end
    step(3);
    do_press(1, 1);
    n_vec++; if (bus.lockout !== 2'b11) begin n_err++; $display("FAIL alllock_both got %b exp %b", bus.lockout, 2'b11); end
    n_vec++; if (bus.round_active !== 1'b0) begin n_err++; $display("FAIL alllock_to_next got %b exp 0", bus.round_active); end
    step(1);
    n_vec++; if (bus.lockout !== 2'b00) begin n_err++; $display("FAIL alllock_clear got %b exp %b", bus.lockout, 2'b00); end
    n_vec++; if (bus.q_idx !== 4'd1) begin n_err++; $display("FAIL alllock_q_idx got %h exp %h", bus.q_idx, 4'd1); end
    n_vec++; if (bus.score !== 8'h00) begin n_err++; $display("FAIL alllock_score got %h exp %h", bus.score, 8'h00); end
    step(2);
  endtask

  task automatic test_wrap();
    bus.q_ans = 4'd1;
    repeat (8) begin
      do_press(0, 1);
      step(3);
      do_press(1, 1);
      step(3);
    end
    n_vec++; if (bus.q_idx !== 4'd9) begin n_err++; $display("FAIL wrap_last got %h exp %h", bus.q_idx, 4'd9); end
    do_press(0, 1);
    step(3);
    do_press(1, 1);
    step(3);
    n_vec++; if (bus.q_idx !== 4'd0) begin n_err++; $display("FAIL wrap_zero got %h exp %h", bus.q_idx, 4'd0); end
  endtask

  task automatic test_win_p1();
    bus.q_ans = 4'd1;
    repeat (5) begin
      do_press(1, 0);
      step(3);
    end
    n_vec++; if (bus.score !== 8'h50) begin n_err++; $display("FAIL p1win_score got %h exp %h", bus.score, 8'h50); end
    n_vec++; if (bus.winner !== 2'd1) begin n_err++; $display("FAIL p1win_winner got %h exp %h", bus.winner, 2'd1); end
    n_vec++; if (bus.game_over !== 1'b1) begin n_err++; $display("FAIL p1win_game_over got %b exp 1", bus.game_over); end
  endtask

  task automatic test_reset_mid_judge();
    pulse_start();
    bus.q_ans = 4'd1;
    do_press(0, 0);
    step(3);
    bus.btn_n[0] = 1'b0;
    step(3);
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.score !== 8'h00) begin n_err++; $display("FAIL midrst_score got %h exp %h", bus.score, 8'h00); end
    n_vec++; if (bus.q_idx !== 4'd0) begin n_err++; $display("FAIL midrst_q_idx got %h exp %h", bus.q_idx, 4'd0); end
    n_vec++; if (bus.lockout !== 2'b00) begin n_err++; $display("FAIL midrst_lockout got %b exp %b", bus.lockout, 2'b00); end
    n_vec++; if (bus.round_active !== 1'b0) begin n_err++; $display("FAIL midrst_round_active got %b exp 0", bus.round_active); end
    n_vec++; if (bus.beep !== 1'b0) begin n_err++; $display("FAIL midrst_beep got %b exp 0", bus.beep); end
    n_vec++; if (bus.game_over !== 1'b0) begin n_err++; $display("FAIL midrst_game_over got %b exp 0", bus.game_over); end
    n_vec++; if (bus.winner !== 2'd0) begin n_err++; $display("FAIL midrst_winner got %h exp %h", bus.winner, 2'd0); end
    step(1);
    rst_n = 1'b1;
    step(6);
    n_vec++; if (bus.score !== 8'h00) begin n_err++; $display("FAIL postrst_score got %h exp %h", bus.score, 8'h00); end
    n_vec++; if (bus.round_active !== 1'b0) begin n_err++; $display("FAIL postrst_idle got %b exp 0", bus.round_active); end
    bus.btn_n = '1;
    step(2);
    pulse_start();
    n_vec++; if (bus.round_active !== 1'b1) begin n_err++; $display("FAIL postrst_start got %b exp 1", bus.round_active); end
    n_vec++; if (bus.score !== 8'h00) begin n_err++; $display("FAIL postrst_start_score got %h exp %h", bus.score, 8'h00); end
  endtask

`ifdef QUIZ_TIMEOUT_EN
  task automatic test_timeout();
    tbus.start = 1'b1;
    step(1);
    tbus.start = 1'b0;
    step(15);
    n_vec++; if (tbus.q_idx !== 4'd0) begin n_err++; $display("FAIL tmo_early got %h exp %h", tbus.q_idx, 4'd0); end
    n_vec++; if (tbus.round_active !== 1'b1) begin n_err++; $display("FAIL tmo_still_ask got %b exp 1", tbus.round_active); end
    step(1);
    n_vec++; if (tbus.round_active !== 1'b0) begin n_err++; $display("FAIL tmo_to_next got %b exp 0", tbus.round_active); end
    step(1);
    n_vec++; if (tbus.q_idx !== 4'd1) begin n_err++; $display("FAIL tmo_q_idx got %h exp %h", tbus.q_idx, 4'd1); end
    n_vec++; if (tbus.score !== 8'h00) begin n_err++; $display("FAIL tmo_score got %h exp %h", tbus.score, 8'h00); end
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.btn_n = '1;
    bus.q_ans = 4'd0;
`ifdef QUIZ_TIMEOUT_EN
    tbus.start = 1'b0;
    tbus.btn_n = '1;
    tbus.q_ans = 4'd1;
`endif
    @(negedge clk);
    test_reset();
    test_start();
    test_correct();
    test_lockout();
    test_simultaneous();
    test_win_p0();
    test_all_locked();
    test_wrap();
    test_win_p1();
    test_reset_mid_judge();
`ifdef QUIZ_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
